// File: rtl/nios2_oci_trace_pkg.sv
// rtl/nios2_oci_trace_pkg.sv - shared types and width helpers for the OCI trace capture path
package nios2_oci_trace_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        ENDED = 2'd3
    } trace_state_t;

    localparam int OVF_W = 16;

    // Width of a counter that must hold 0..frags_per_word inclusive.
    function automatic int cnt_width(input int frags_per_word);
        return $clog2(frags_per_word + 1);
    endfunction

    // Width of a level counter that must hold 0..depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/nios2_oci_trace_fifo.sv
// rtl/nios2_oci_trace_fifo.sv - circular buffer with drop/overwrite full policy and overflow event
module nios2_oci_trace_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int WRAP  = 0,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,        // write push_data this cycle
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,         // consumer ready; ignored while empty
    output logic             head_valid,  // head_data holds the oldest entry
    output logic [WIDTH-1:0] head_data,
    output logic [LVL_W-1:0] level,       // occupied entries
    output logic             overflow     // a push hit a full buffer with no pop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_pop;
    logic             do_write;
    logic             overwrite;

    assign full       = (level == LVL_W'(DEPTH));
    assign empty      = (level == '0);
    assign do_pop     = pop && !empty;
    assign overflow   = push && full && !do_pop;
    // In overwrite mode a full buffer has wr_ptr == rd_ptr, so writing the
    // oldest slot and bumping both pointers replaces the oldest entry.
    assign overwrite  = overflow && (WRAP != 0);
    assign do_write   = push && (!overflow || overwrite);
    assign head_valid = !empty;
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop || overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_write && !do_pop && !overwrite) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_write) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// rtl/nios2_oci_trace_capture.sv - trace fragment packer, queue and end-of-test flush/drain control
module nios2_oci_trace_capture
    import nios2_oci_trace_pkg::*;
#(
    parameter int FRAG_W         = 10,
    parameter int FRAGS_PER_WORD = 3,
    parameter int DEPTH          = 16,
    parameter int WRAP           = 0,
    localparam int WORD_W = FRAGS_PER_WORD * FRAG_W,
    localparam int CNT_W  = cnt_width(FRAGS_PER_WORD),
    localparam int LVL_W  = lvl_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frag_valid,     // one fragment per cycle
    input  logic [FRAG_W-1:0] frag_data,
    input  logic              test_ending,    // end-of-test request
    input  logic              rd_ready,       // consumer takes rd_data
    output logic              rd_valid,       // queue head valid
    output logic [WORD_W-1:0] rd_data,        // queue head word
    output logic [CNT_W-1:0]  rd_count,       // fragments valid in rd_data
    output logic [WORD_W-1:0] dct_buffer,     // partial packer contents
    output logic [CNT_W-1:0]  dct_count,      // fragments held in packer
    output logic [LVL_W-1:0]  fifo_level,     // occupied queue entries
    output logic [OVF_W-1:0]  overflow_cnt,   // lost/overwritten words, saturating
    output logic              test_has_ended  // flush and drain complete
);

    trace_state_t              state;
    logic [WORD_W-1:0]         pack_buf;
    logic [CNT_W-1:0]          pack_cnt;
    logic [WORD_W-1:0]         merged;
    logic                      take_frag;
    logic                      word_done;
    logic                      flush_push;
    logic                      push;
    logic [CNT_W+WORD_W-1:0]   push_entry;
    logic [CNT_W+WORD_W-1:0]   head_entry;
    logic                      overflow_evt;

    assign take_frag  = (state == RUN) && frag_valid;
    assign merged     = pack_buf | (WORD_W'(frag_data) << (int'(pack_cnt) * FRAG_W));
    assign word_done  = take_frag && (pack_cnt == CNT_W'(FRAGS_PER_WORD - 1));
    assign flush_push = (state == FLUSH) && (pack_cnt != '0);
    assign push       = word_done || flush_push;
    // A completing fragment and a flush can never coincide: flush only runs
    // outside RUN, where fragments are ignored.
    assign push_entry = word_done ? {CNT_W'(FRAGS_PER_WORD), merged}
                                  : {pack_cnt, pack_buf};

    nios2_oci_trace_fifo #(
        .WIDTH (CNT_W + WORD_W),
        .DEPTH (DEPTH),
        .WRAP  (WRAP)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (push_entry),
        .pop        (rd_ready),
        .head_valid (rd_valid),
        .head_data  (head_entry),
        .level      (fifo_level),
        .overflow   (overflow_evt)
    );

    assign rd_data    = head_entry[WORD_W-1:0];
    assign rd_count   = head_entry[CNT_W+WORD_W-1:WORD_W];
    assign dct_buffer = pack_buf;
    assign dct_count  = pack_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RUN;
            pack_buf       <= '0;
            pack_cnt       <= '0;
            overflow_cnt   <= '0;
            test_has_ended <= 1'b0;
        end else begin
            if (take_frag) begin
                if (word_done) begin
                    pack_buf <= '0;
                    pack_cnt <= '0;
                end else begin
                    pack_buf <= merged;
                    pack_cnt <= pack_cnt + 1'b1;
                end
            end else if (flush_push) begin
                pack_buf <= '0;
                pack_cnt <= '0;
            end

            if (overflow_evt && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end

            case (state)
                RUN: begin
                    if (test_ending) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_level == '0) begin
                        state          <= ENDED;
                        test_has_ended <= 1'b1;
                    end
                end
                ENDED: begin
                    test_has_ended <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
